// File: rtl/bvshl_ugt_skolem_seq.sv
// Sequential Skolem-witness search for (x << s) >u t (MODE 0) or (s << x) >u t (MODE 1).
// Accepts one (s, t) request at a time and returns the minimal witness x, a found flag
// and the number of candidates evaluated. Candidates are tried in increasing order, one
// per cycle.
module bvshl_ugt_skolem_seq #(
    parameter int unsigned W    = 4,
    parameter int unsigned MODE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] s,
    input  logic [W-1:0] t,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] x,
    output logic         found,
    output logic [W:0]   iters
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSearch = 2'd1,
        StDone   = 2'd2
    } state_e;

    // Last candidate: every value for MODE 0; only in-range shift amounts for MODE 1,
    // since any larger shift of s yields 0 and can never exceed t.
    localparam logic [W-1:0] Last = (MODE == 0) ? {W{1'b1}} : W'(W - 1);

    state_e       state_q, state_d;
    logic [W-1:0] s_q, s_d;
    logic [W-1:0] t_q, t_d;
    logic [W-1:0] cand_q, cand_d;
    logic [W-1:0] x_q, x_d;
    logic         found_q, found_d;
    logic [W:0]   iters_q, iters_d;

    logic [W-1:0] ic_mask;
    logic         ic;
    logic [W-1:0] shifted;
    logic         hit;

    // Invertibility condition and per-candidate hit test.
    always_comb begin
        // Shifts of W or more produce 0 under SystemVerilog logical-shift rules.
        ic_mask = {W{1'b1}} << s;
        ic      = (t < ic_mask);
        if (MODE == 0) begin
            shifted = cand_q << s_q;
        end else begin
            shifted = s_q << cand_q;
        end
        hit = (shifted > t_q);
    end

    // Next-state logic for the handshake FSM and the search datapath.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        t_d     = t_q;
        cand_d  = cand_q;
        x_d     = x_q;
        found_d = found_q;
        iters_d = iters_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    s_d     = s;
                    t_d     = t;
                    cand_d  = '0;
                    iters_d = '0;
                    x_d     = '0;
                    found_d = 1'b0;
                    // MODE 0 can reject up front: no witness exists unless t < (~0 << s).
                    if ((MODE == 0) && !ic) begin
                        state_d = StDone;
                    end else begin
                        state_d = StSearch;
                    end
                end
            end
            StSearch: begin
                iters_d = iters_q + 1'b1;
                if (hit) begin
                    x_d     = cand_q;
                    found_d = 1'b1;
                    state_d = StDone;
                end else if (cand_q == Last) begin
                    x_d     = '0;
                    found_d = 1'b0;
                    state_d = StDone;
                end else begin
                    cand_d = cand_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            s_q     <= '0;
            t_q     <= '0;
            cand_q  <= '0;
            x_q     <= '0;
            found_q <= 1'b0;
            iters_q <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            t_q     <= t_d;
            cand_q  <= cand_d;
            x_q     <= x_d;
            found_q <= found_d;
            iters_q <= iters_d;
        end
    end

    // Outputs come straight from state and registers.
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        x         = x_q;
        found     = found_q;
        iters     = iters_q;
    end

endmodule

// File: doc/bvshl_ugt_skolem_seq.md
# bvshl_ugt_skolem_seq

Sequential, parametrised Skolem-witness engine for the invertibility problem "find x such that (x << s) >u t" (MODE 0) or "(s << x) >u t" (MODE 1) over W-bit bit-vectors. It generalises the fixed 4-bit combinational witness functions to arbitrary width with a selectable shift operand. Instead of a flat formula, it uses a valid/ready handshake and an iterative candidate search. It always returns the minimal witness, a found flag, and the number of candidates evaluated. It sits beside the combinational Skolem blocks as a reference checker and as a fallback for widths too wide to synthesise flat.

## Interface
- W, default 4: bit-vector width (W >= 2).
- MODE, default 0: 0 = solve (x << s) >u t for x; 1 = solve (s << x) >u t for x.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; one clock, synchronous and active-low.
- in_valid  in  1  a request (s, t) is presented.
- in_ready  out  1  block can accept a request; high only in IDLE.
- s  in  W  operand s, sampled on accept.
- t  in  W  operand t, sampled on accept.
- out_valid  out  1  result (x, found, iters) is valid.
- out_ready  in  1  consumer accepts the result.
- x  out  W  minimal witness when found=1, else 0.
- found  out  1  1 = a witness exists (invertibility condition holds).
- iters  out  W+1  number of candidates evaluated.

## Operation
- Arithmetic:
  - bvshl is a logical left shift, result truncated to W bits.
  - A shift amount >= W gives 0.
  - >u is an unsigned compare.
- States: IDLE, SEARCH, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - An accept occurs when in_valid && in_ready. On accept, s and t are registered, the candidate counter cand is set to 0, and iters is set to 0.
  - MODE 0: compute ic = t <u (~0 << s) from the live inputs. If ic=0, go to DONE with found=0, x=0, iters=0. Otherwise go to SEARCH.
  - MODE 1: always go to SEARCH.
- SEARCH, one candidate per cycle:
  - Evaluate hit = (MODE0: (cand << s_r) >u t_r; MODE1: (s_r << cand) >u t_r). Increment iters.
  - If hit: go to DONE with x=cand, found=1.
  - Else if cand == LAST: go to DONE with x=0, found=0.
  - Else: cand <= cand+1.
  - LAST is 2^W-1 for MODE 0 and W-1 for MODE 1; shifts >= W never hit.
  - In MODE 0, ic=1 guarantees a hit no later than cand=2^W-1.
- DONE:
  - out_valid=1. x, found and iters are held stable while out_ready=0.
  - On out_valid && out_ready, go to IDLE.
- No new request is accepted until the result handshake completes; no pipelining.
- Reset (rst_n=0 at a clock edge), from any state including mid-SEARCH and DONE:
  - State returns to IDLE and the pending result is discarded.
  - Outputs: in_ready=1, out_valid=0, x=0, found=0, iters=0.

## Timing
- Let the accept occur at edge k and the hit occur at candidate n.
- Hit at n: SEARCH evaluates candidate 0 in the cycle after edge k; out_valid is first high in the cycle after edge k+n+1 (n+2 edges after accept). iters=n+1.
- MODE 0 with ic=0: out_valid is high in the cycle after edge k (1-cycle latency). iters=0.
- Exhaustion (no hit): out_valid after k+LAST+2 edges. iters=LAST+1.
- Worst-case latency: 2^W+1 edges (MODE 0), W+1 edges (MODE 1).
- With out_ready held high, DONE lasts exactly one cycle. in_ready rises in the cycle after the result handshake.
- Outputs are registered; there is no combinational path from in_valid/s/t to the outputs.
- in_ready depends only on state; it does not depend combinationally on out_ready.

## Test plan
- MODE 0, W=4, s=2, t=9 -> found=1, x=3, iters=4; out_valid 5 edges after accept.
- MODE 0, W=4, threshold and large-shift cases:
  - s=3, t=8 -> found=0, x=0, iters=0, out_valid 1 edge after accept.
  - s=5, t=0 (shift >= W) -> found=0, same 1-edge latency.
- MODE 0, W=4, boundary compares:
  - s=0, t=14 -> found=1, x=15, iters=16, latency 17.
  - s=0, t=15 -> found=0, iters=0.
- MODE 1, W=4:
  - s=1, t=5 -> found=1, x=3, iters=4.
  - s=8, t=8 -> found=0, x=0, iters=4, latency 5.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout; release -> in_ready=1 on the next cycle.
  - Assert rst_n=0 mid-SEARCH (MODE 0, s=0, t=14, at iters=6) -> next cycle in_ready=1, out_valid=0, iters=0.
  - A new request after that reset completes correctly.
- Exhaustive compare, W=4, both MODEs: all 256 (s,t) pairs against the golden rule, which is the minimal x satisfying the formula, or found=0 if no x satisfies it. This includes random out_ready stalls and back-to-back in_valid.
